mem_arbiter: RTL and testbench



---
 rtl/aww_types_pkg.sv | 18 +
 rtl/cpu_types_pkg.sv | 17 +
 rtl/mem_arbiter_rr_picker.sv | 35 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aww_types_pkg.sv
// rtl/aww_types_pkg.sv - memory arbiter state type and helpers
//
// Purpose: arbiter FSM encoding and the round-robin pointer advance.
// Contents: arb_state_t (IDLE, DSERV, ISERV), rr_next().
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } arb_state_t;

  // Pointer to the core after cur, wrapping at n.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1) % n;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM interface types
//
// Purpose: word type and RAM handshake states used by the caches,
// the memory arbiter and the RAM model.
// Contents: word_t (32-bit word), ramstate_t (FREE, BUSY, ACCESS, ERROR).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - round-robin requester picker
//
// Purpose: picks the first asserted request at or after ptr, wrapping.
// Ports:
//   req   in  NCPUS  request vector, one bit per core
//   ptr   in  IW     core with highest priority this decision
//   valid out 1      any request asserted
//   idx   out IW     winning core (0 when valid is low)
module rr_picker #(
  parameter int NCPUS = 2,
  localparam int IW = (NCPUS > 1) ? $clog2(NCPUS) : 1
) (
  input  logic [NCPUS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit to ptr
  // is the last assignment and therefore wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int k = NCPUS - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NCPUS);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - RAM port arbiter for NCPUS icache/dcache pairs
//
// Purpose: shares one RAM port between every core's icache and dcache.
// dcache grants are held across a block burst (bounded by MAXBURST RAM
// completions) so writeback plus fetch stays atomic; dcache beats icache,
// and each class rotates round-robin among cores.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN, iaddr        icache read request / word address per core
//   iwait, iload       icache stall (low only on completion) / read data
//   dREN, dWEN         dcache read / write request per core
//   daddr, dstore      dcache word address / write data per core
//   dwait, dload       dcache stall (low only on completion) / read data
//   ramREN, ramWEN     RAM read / write enable
//   ramaddr, ramstore  RAM address / write data
//   ramload, ramstate  RAM read data / handshake state
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int NCPUS    = 2,
  parameter int MAXBURST = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCPUS-1:0]       iREN,
  input  logic [NCPUS-1:0][31:0] iaddr,
  output logic [NCPUS-1:0]       iwait,
  output logic [NCPUS-1:0][31:0] iload,
  input  logic [NCPUS-1:0]       dREN,
  input  logic [NCPUS-1:0]       dWEN,
  input  logic [NCPUS-1:0][31:0] daddr,
  input  logic [NCPUS-1:0][31:0] dstore,
  output logic [NCPUS-1:0]       dwait,
  output logic [NCPUS-1:0][31:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate
);

  localparam int CW = (NCPUS > 1) ? $clog2(NCPUS) : 1;
  localparam int BW = $clog2(MAXBURST + 1);

  arb_state_t    state;
  logic [CW-1:0] gnt_cpu;
  logic          gnt_is_d;
  logic [CW-1:0] rr_d;
  logic [CW-1:0] rr_i;
  logic [BW-1:0] burst_cnt;

  logic [NCPUS-1:0] d_req;
  logic             d_valid;
  logic             i_valid;
  logic [CW-1:0]    d_pick;
  logic [CW-1:0]    i_pick;
  logic             access;
  logic             g_dreq;
  logic             g_ireq;
  logic [CW-1:0]    gnt_next;

  assign d_req    = dREN | dWEN;
  assign access   = (ramstate == ACCESS);
  assign g_dreq   = d_req[gnt_cpu];
  assign g_ireq   = iREN[gnt_cpu];
  assign gnt_next = CW'(rr_next(int'(gnt_cpu), NCPUS));

  rr_picker #(.NCPUS(NCPUS)) u_pick_d (
    .req   (d_req),
    .ptr   (rr_d),
    .valid (d_valid),
    .idx   (d_pick)
  );

  rr_picker #(.NCPUS(NCPUS)) u_pick_i (
    .req   (iREN),
    .ptr   (rr_i),
    .valid (i_valid),
    .idx   (i_pick)
  );

  // Grant FSM. The grant only moves in IDLE, so a request raised while
  // another core is being served waits for the next IDLE decision.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      gnt_cpu   <= '0;
      gnt_is_d  <= 1'b0;
      rr_d      <= '0;
      rr_i      <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            state    <= DSERV;
            gnt_cpu  <= d_pick;
            gnt_is_d <= 1'b1;
          end else if (i_valid) begin
            state    <= ISERV;
            gnt_cpu  <= i_pick;
            gnt_is_d <= 1'b0;
          end
        end
        DSERV: begin
          if (!g_dreq) begin
            state     <= IDLE;
            rr_d      <= gnt_next;
            burst_cnt <= '0;
          end else if (access) begin
            // The completion that would reach MAXBURST releases instead.
            if (burst_cnt == BW'(MAXBURST - 1)) begin
              state     <= IDLE;
              rr_d      <= gnt_next;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
        end
        ISERV: begin
          if (!g_ireq || access) begin
            state <= IDLE;
            rr_i  <= gnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM drive and waits decode from the registered grant, so an
  // asynchronous reset drops the RAM enables without waiting for a clock.
  // Address and data follow the granted core's live inputs because a
  // dcache walks its block words while keeping its request asserted.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state != IDLE) begin
      if (gnt_is_d) begin
        ramaddr        = daddr[gnt_cpu];
        ramstore       = dstore[gnt_cpu];
        ramWEN         = dWEN[gnt_cpu];
        ramREN         = dREN[gnt_cpu] & ~dWEN[gnt_cpu];
        dwait[gnt_cpu] = ~access;
      end else begin
        ramREN         = 1'b1;
        ramaddr        = iaddr[gnt_cpu];
        iwait[gnt_cpu] = ~access;
      end
    end
  end

  // Read data is broadcast; only the wait lines say whose it is.
  assign iload = {NCPUS{ramload}};
  assign dload = {NCPUS{ramload}};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  import aww_types_pkg::*;

  localparam int N  = 2;
  localparam int MB = 4;

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic [N-1:0]        iREN = '0;
  logic [N-1:0][31:0]  iaddr = '0;
  logic [N-1:0]        iwait;
  logic [N-1:0][31:0]  iload;
  logic [N-1:0]        dREN = '0;
  logic [N-1:0]        dWEN = '0;
  logic [N-1:0][31:0]  daddr = '0;
  logic [N-1:0][31:0]  dstore = '0;
  logic [N-1:0]        dwait;
  logic [N-1:0][31:0]  dload;
  logic                ramREN;
  logic                ramWEN;
  logic [31:0]         ramaddr;
  logic [31:0]         ramstore;
  logic [31:0]         ramload = '0;
  logic [1:0]          ramstate = FREE;

  mem_arbiter #(.NCPUS(N), .MAXBURST(MB)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    bit          both;
    logic [31:0] addr;
    logic [31:0] data;
    bit          cont;
  } dop_t;

  // Per-core pending work; a dcache op with cont=0 ends its block and the
  // requester drops for one cycle afterwards.
  dop_t        dq [N][$];
  logic [31:0] iq [N][$];
  bit          dgap [N];

  // Reference model: who owns the RAM port, how many words it has had,
  // and which core each class starts searching from next time.
  int m_own;    // 0 none, 1 dcache, 2 icache
  int m_core;
  int m_cnt;
  int m_rrd;
  int m_rri;

  // RAM model
  int  lat;
  int  busy_left;
  bit  rand_lat;
  bit  err_en;
  bit  force_ld;
  logic [31:0] ld_val;

  logic [39:0] log_q[$];
  logic [39:0] exp_q[$];

  // Values sampled at the last step's check point
  logic        s_ren;
  logic [31:0] s_addr;
  logic [N-1:0] s_iw;
  logic [31:0] s_iload0;
  logic [1:0]  s_state;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ent(input int k, input int c, input logic [31:0] a);
    return {4'(k), 4'(c), a};
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_own == 1) return DSERV;
    if (m_own == 2) return ISERV;
    return IDLE;
  endfunction

  task automatic model_reset();
    m_own = 0; m_core = 0; m_cnt = 0; m_rrd = 0; m_rri = 0;
    busy_left = lat;
    for (int c = 0; c < N; c++) begin
      dgap[c] = 1'b0;
      dq[c].delete();
      iq[c].delete();
    end
  endtask

  // One clock: drive requests, let the RAM answer, check at the falling
  // edge, then advance model and requesters at the rising edge.
  task automatic step();
    logic         e_ren, e_wen;
    logic [31:0]  e_addr, e_store;
    logic [N-1:0] e_iw, e_dw;
    int           g;
    bit           acc, found;
    for (int c = 0; c < N; c++) begin
      if (!dgap[c] && dq[c].size() > 0) begin
        dWEN[c]   = dq[c][0].wr;
        dREN[c]   = !dq[c][0].wr || dq[c][0].both;
        daddr[c]  = dq[c][0].addr;
        dstore[c] = dq[c][0].data;
      end else begin
        dWEN[c] = 1'b0; dREN[c] = 1'b0;
        daddr[c] = $urandom; dstore[c] = $urandom;
      end
      iREN[c]  = (iq[c].size() > 0);
      iaddr[c] = (iq[c].size() > 0) ? iq[c][0] : $urandom;
    end
    g = m_core;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (m_own == 1) begin
      e_wen = dWEN[g]; e_ren = dREN[g] && !dWEN[g];
      e_addr = daddr[g]; e_store = dstore[g];
    end else if (m_own == 2) begin
      e_ren = 1'b1; e_addr = iaddr[g];
    end
    if (e_ren || e_wen) begin
      if (busy_left > 0) begin
        if (err_en && $urandom_range(0, 3) == 0) ramstate = ERROR;
        else begin ramstate = BUSY; busy_left--; end
      end else begin
        ramstate = ACCESS;
        busy_left = rand_lat ? $urandom_range(0, 2) : lat;
      end
    end else begin
      ramstate = FREE;
    end
    ramload = force_ld ? ld_val : $urandom;
    acc = (ramstate == ACCESS);
    e_dw = '1; e_iw = '1;
    if (m_own == 1) e_dw[g] = !acc;
    if (m_own == 2) e_iw[g] = !acc;

    @(negedge CLK);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    if (e_ren || e_wen) chk("ramaddr", ramaddr, e_addr);
    if (e_wen) chk("ramstore", ramstore, e_store);
    chk("dwait", dwait, e_dw);
    chk("iwait", iwait, e_iw);
    for (int c = 0; c < N; c++) begin
      chk("iload", iload[c], ramload);
      chk("dload", dload[c], ramload);
    end
    chk("state", dut.state, exp_state());
    chk("rr_d", dut.rr_d, m_rrd);
    chk("rr_i", dut.rr_i, m_rri);
    chk("burst_cnt", dut.burst_cnt, m_cnt);
    s_ren = ramREN; s_addr = ramaddr; s_iw = iwait; s_iload0 = iload[0]; s_state = dut.state;
    for (int c = 0; c < N; c++) begin
      if (dwait[c] === 1'b0) log_q.push_back(ent(1, c, ramaddr));
      if (iwait[c] === 1'b0) log_q.push_back(ent(2, c, ramaddr));
    end

    @(posedge CLK);
    case (m_own)
      0: begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c = (m_rrd + k) % N;
          if (!found && (dREN[c] || dWEN[c])) begin found = 1'b1; m_own = 1; m_core = c; end
        end
        for (int k = 0; k < N; k++) begin
          int c = (m_rri + k) % N;
          if (!found && iREN[c]) begin found = 1'b1; m_own = 2; m_core = c; end
        end
      end
      1: begin
        if (!(dREN[g] || dWEN[g])) begin
          m_own = 0; m_cnt = 0; m_rrd = (g + 1) % N;
        end else if (acc) begin
          m_cnt++;
          if (m_cnt == MB) begin m_own = 0; m_cnt = 0; m_rrd = (g + 1) % N; end
        end
      end
      default: begin
        if (!iREN[g] || acc) begin m_own = 0; m_rri = (g + 1) % N; end
      end
    endcase
    for (int c = 0; c < N; c++) begin
      if (dgap[c]) dgap[c] = 1'b0;
      else if (dq[c].size() > 0 && !e_dw[c]) begin
        dgap[c] = !dq[c][0].cont;
        dq[c].delete(0);
      end
      if (iq[c].size() > 0 && !e_iw[c]) iq[c].delete(0);
    end
    #1;
  endtask

  function automatic bit busy();
    bit b = (m_own != 0);
    for (int c = 0; c < N; c++) b = b || dq[c].size() > 0 || iq[c].size() > 0 || dgap[c];
    return b;
  endfunction

  task automatic run(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin step(); n++; end
    chk("run_bound", (n < maxc), 1'b1);
  endtask

  task automatic push_d(input int c, input bit wr, input logic [31:0] a, input bit cont);
    dop_t op;
    op.wr = wr; op.both = 1'b0; op.addr = a; op.data = $urandom; op.cont = cont;
    dq[c].push_back(op);
  endtask

  task automatic chk_log(input string tag);
    chk($sformatf("%s_n", tag), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk(tag, log_q[i], exp_q[i]);
    log_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    dREN = '0; dWEN = '0; iREN = '0; ramstate = FREE;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lat = 1; rand_lat = 1'b0; err_en = 1'b0; force_ld = 1'b0; ld_val = '0;
    model_reset();

    // Reset values
    @(negedge CLK);
    chk("rst_state", dut.state, IDLE);
    chk("rst_gnt_cpu", dut.gnt_cpu, 0);
    chk("rst_gnt_is_d", dut.gnt_is_d, 0);
    chk("rst_rr_d", dut.rr_d, 0);
    chk("rst_rr_i", dut.rr_i, 0);
    chk("rst_burst_cnt", dut.burst_cnt, 0);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ren_wen", {ramREN, ramWEN}, 2'b00);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Single read, RAM answers on the second drive cycle
    lat = 1; busy_left = 1; force_ld = 1'b1; ld_val = 32'hDEAD_BEEF;
    iq[0].push_back(32'h40);
    step();
    chk("sr_c0_ren", s_ren, 1'b0);
    step();
    chk("sr_c1_ren", s_ren, 1'b1);
    chk("sr_c1_addr", s_addr, 32'h40);
    chk("sr_c1_iwait", s_iw, 2'b11);
    step();
    chk("sr_c2_iwait", s_iw, 2'b10);
    chk("sr_c2_iload", s_iload0, 32'hDEAD_BEEF);
    step();
    chk("sr_c3_state", s_state, IDLE);
    chk("sr_c3_iwait", s_iw, 2'b11);
    force_ld = 1'b0; log_q.delete();

    // dcache beats icache raised in the same cycle
    iq[0].push_back(32'h80);
    push_d(1, 1'b0, 32'h100, 1'b0);
    run(100);
    exp_q.push_back(ent(1, 1, 32'h100));
    exp_q.push_back(ent(2, 0, 32'h80));
    chk_log("prio");

    // Writeback plus fetch held atomic against a pending core1 request
    push_d(0, 1'b1, 32'h200, 1'b1);
    push_d(0, 1'b1, 32'h204, 1'b1);
    push_d(0, 1'b0, 32'h300, 1'b1);
    push_d(0, 1'b0, 32'h304, 1'b0);
    push_d(1, 1'b0, 32'h500, 1'b0);
    run(200);
    exp_q.push_back(ent(1, 0, 32'h200));
    exp_q.push_back(ent(1, 0, 32'h204));
    exp_q.push_back(ent(1, 0, 32'h300));
    exp_q.push_back(ent(1, 0, 32'h304));
    exp_q.push_back(ent(1, 1, 32'h500));
    chk_log("atomic");

    // Forced release after MAXBURST completions
    for (int k = 0; k < 6; k++) push_d(0, 1'b0, 32'h600 + 32'(4 * k), k != 5);
    push_d(1, 1'b0, 32'h700, 1'b0);
    run(300);
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(1, 0, 32'h600 + 32'(4 * k)));
    exp_q.push_back(ent(1, 1, 32'h700));
    exp_q.push_back(ent(1, 0, 32'h610));
    exp_q.push_back(ent(1, 0, 32'h614));
    chk_log("forced");

    // Round-robin between single-word dcache requests
    do_reset();
    lat = 0; busy_left = 0;
    push_d(0, 1'b0, 32'h800, 1'b0);
    push_d(0, 1'b0, 32'h808, 1'b0);
    push_d(1, 1'b0, 32'h900, 1'b0);
    push_d(1, 1'b0, 32'h908, 1'b0);
    run(200);
    exp_q.push_back(ent(1, 0, 32'h800));
    exp_q.push_back(ent(1, 1, 32'h900));
    exp_q.push_back(ent(1, 0, 32'h808));
    exp_q.push_back(ent(1, 1, 32'h908));
    chk_log("rr");

    // Randomised traffic with variable latency and ERROR retries
    rand_lat = 1'b1; err_en = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (dq[c].size() == 0 && !dgap[c] && $urandom_range(0, 3) == 0) begin
          int len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) begin
            dop_t op;
            op.wr = $urandom_range(0, 1);
            op.both = op.wr && ($urandom_range(0, 3) == 0);
            op.addr = $urandom; op.data = $urandom;
            op.cont = (k != len - 1);
            dq[c].push_back(op);
          end
        end
        if (iq[c].size() == 0 && $urandom_range(0, 2) == 0) iq[c].push_back($urandom);
      end
      step();
    end
    run(2000);
    log_q.delete();

    // Asynchronous reset in the middle of a dcache write
    rand_lat = 1'b0; err_en = 1'b0; lat = 0; busy_left = 0;
    push_d(0, 1'b0, 32'hA00, 1'b0);
    run(100);
    lat = 5; busy_left = 5;
    push_d(1, 1'b1, 32'hB00, 1'b0);
    step();
    step();
    chk("mid_pre_wen", ramWEN, 1'b1);
    chk("mid_pre_rr_d", dut.rr_d, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_wen", ramWEN, 1'b0);
    chk("mid_ren", ramREN, 1'b0);
    chk("mid_dwait", dwait, 2'b11);
    chk("mid_iwait", iwait, 2'b11);
    chk("mid_state", dut.state, IDLE);
    chk("mid_rr_d", dut.rr_d, 0);
    chk("mid_burst_cnt", dut.burst_cnt, 0);
    dREN = '0; dWEN = '0; iREN = '0; ramstate = FREE;
    lat = 0;
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    step();
    chk("post_state", s_state, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
